ram_stream_reader: RTL and testbench

Sequential read master for the single-port particle-data RAM (registered-output, 2-cycle read latency). A start command with base address and word count makes it issue back-to-back reads, absorb the RAM pipeline latency in a credit-controlled output FIFO, and present the words as a valid/ready stream with a last flag. It sits between a particle RAM and the motion-update datapath, and drives that RAM's address, wren and data inputs.

---
 rtl/ram_stream_reader.sv | 132 +++++++++++++
 tb/tb_ram_stream_reader.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Sequential read master for a registered-output (2-cycle latency) single-port RAM. Issues
// back-to-back reads and returns the words as a valid/ready stream through a credit-checked FIFO.
module ram_stream_reader #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_wren,
  output logic [WIDTH-1:0]      ram_data,
  input  logic [WIDTH-1:0]      ram_q,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] RemOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;

  // Read tokens: bit 0 is stage 1, bit 1 is stage 2 (aligned with ram_q).
  logic [1:0]            tok_vld_q, tok_last_q;

  logic [WIDTH-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
  logic [CntW-1:0]       fifo_count_q;

  logic [1:0]            inflight;
  logic                  credit_ok, issue, push, pop, head_last;

  assign inflight  = 2'(tok_vld_q[0]) + 2'(tok_vld_q[1]);
  // Every issued read already owns a FIFO slot, so capture can never overflow.
  assign credit_ok = ({1'b0, fifo_count_q} + (CntW+1)'(inflight)) < (CntW+1)'(FIFO_DEPTH);
  assign issue     = (state_q == StRead) && (remaining_q != '0) && credit_ok;
  assign push      = tok_vld_q[1];
  assign out_valid = (fifo_count_q != '0);
  assign pop       = out_valid && out_ready;
  assign head_last = fifo_last_q[rd_ptr_q];

  assign wr_ptr_nxt = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
  assign rd_ptr_nxt = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);

  assign out_data    = fifo_data_q[rd_ptr_q];
  assign out_last    = out_valid && head_last;
  assign ram_address = addr_ptr_q;
  assign ram_wren    = 1'b0;
  assign ram_data    = '0;
  assign busy        = (state_q == StRead) || (state_q == StDrain);
  assign done        = (state_q == StFin);

  always_comb begin
    state_d     = state_q;
    addr_ptr_d  = addr_ptr_q;
    remaining_d = remaining_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = count;
          if (count == '0) begin
            state_d = StFin;
          end else begin
            addr_ptr_d = base_addr;
            state_d    = StRead;
          end
        end
      end
      StRead: begin
        if (issue) begin
          addr_ptr_d  = (addr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == RemOne) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_last && (inflight == 2'd0)) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_ptr_q  <= '0;
      remaining_q <= '0;
      tok_vld_q   <= '0;
      tok_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_ptr_q  <= addr_ptr_d;
      remaining_q <= remaining_d;
      tok_vld_q   <= {tok_vld_q[0], issue};
      tok_last_q  <= {tok_last_q[0], issue && (remaining_q == RemOne)};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      fifo_last_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_q;
        fifo_last_q[wr_ptr_q] <= tok_last_q[1];
        wr_ptr_q              <= wr_ptr_nxt;
      end
      if (pop) rd_ptr_q <= rd_ptr_nxt;
      fifo_count_q <= fifo_count_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: a behavioural RAM with 2-cycle read latency and an
// expected stream computed from mem[(base+i) % DEPTH].
module tb_ram_stream_reader;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int FD    = 4;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW:0]      count = '0;
  logic             busy, done, ram_wren, out_valid, out_last;
  logic             out_ready = 1'b1;
  logic [AW-1:0]    ram_address;
  logic [WIDTH-1:0] ram_data, ram_q, out_data;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  ram_stream_reader #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .ram_address(ram_address),
    .ram_wren   (ram_wren),
    .ram_data   (ram_data),
    .ram_q      (ram_q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural RAM: address sampled at the edge, registered output one edge later.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ram_a1  = '0;
  logic [WIDTH-1:0] ram_q_r = '0;
  always @(posedge clock) begin
    ram_a1  <= ram_address;
    ram_q_r <= mem[ram_a1];
  end
  assign ram_q = ram_q_r;

  // Ready pattern: 0 = always high, 1 = random, 2 = low for cycles T+5..T+14.
  int ready_mode = 0;
  int t_start    = -1000;
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = !(cyc >= t_start + 5 && cyc <= t_start + 14);
      default: out_ready = 1'b1;
    endcase
  end

  logic             busy_log  [int];
  logic             valid_log [int];
  logic             last_log  [int];
  logic [AW-1:0]    addr_log  [int];
  logic [WIDTH-1:0] data_log  [int];
  logic [WIDTH-1:0] rx_data [$];
  logic             rx_last [$];
  int               rx_cyc  [$];
  int               done_cnt = 0;

  initial forever begin
    @(negedge clock);
    busy_log[cyc]  = busy;
    valid_log[cyc] = out_valid;
    last_log[cyc]  = out_last;
    addr_log[cyc]  = ram_address;
    data_log[cyc]  = out_data;
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
      rx_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] exp_word(input int b, input int i);
    return mem[(b + i) % DEPTH];
  endfunction

  task automatic fill_ramp();
    for (int a = 0; a < DEPTH; a++) mem[a] = 16'(a + 16'h100);
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++) mem[a] = 16'($urandom);
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
    done_cnt = 0;
  endtask

  // Issues one command and waits (bounded) for done; td = -1 if it never came.
  task automatic run_cmd(input int b, input int n, input int mode, input int budget,
                         output int t0, output int td);
    clear_rx();
    @(posedge clock);
    #1;
    start      = 1'b1;
    base_addr  = AW'(b);
    count      = (AW+1)'(n);
    t0         = cyc;
    t_start    = cyc;
    ready_mode = mode;
    @(posedge clock);
    #1;
    start = 1'b0;
    td = -1;
    for (int i = 0; i < budget && td < 0; i++) begin
      @(negedge clock);
      if (done) td = cyc;
    end
    n_asserts++;
    if (td < 0) begin
      n_fail++;
      $display("FAIL cmd_timeout: no done within %0d cycles (base %0d count %0d)", budget, b, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    n_asserts++;
    if ({busy, done, out_valid, out_last} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/done/valid/last=%b required 0000",
               {busy, done, out_valid, out_last});
    end
    n_asserts++;
    if (out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h required 0", out_data);
    end
    n_asserts++;
    if ({ram_address, ram_wren, ram_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_ram_port: addr=%h wren=%b data=%h required 0", ram_address, ram_wren,
               ram_data);
    end
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
    n_asserts++;
    if ({busy, done, out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: busy/done/valid=%b required 000", {busy, done, out_valid});
    end
  endtask

  task automatic test_basic();
    int t0, td;
    fill_ramp();
    run_cmd(16, 4, 0, 100, t0, td);
    repeat (3) @(negedge clock);
    n_asserts++;
    if (rx_data.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d words required 4", rx_data.size());
    end
    for (int i = 0; i < rx_data.size() && i < 4; i++) begin
      n_asserts++;
      if (rx_data[i] !== 16'(16'h110 + i) || rx_last[i] !== (i == 3) || rx_cyc[i] != t0 + 4 + i)
      begin
        n_fail++;
        $display("FAIL basic_word%0d: data=%h last=%b cyc=T+%0d required %h %b T+%0d", i,
                 rx_data[i], rx_last[i], rx_cyc[i] - t0, 16'(16'h110 + i), i == 3, 4 + i);
      end
    end
    n_asserts++;
    if (td != t0 + 8) begin
      n_fail++;
      $display("FAIL basic_done_time: got T+%0d required T+8", td - t0);
    end
    n_asserts++;
    if (busy_log[t0] !== 1'b0 || busy_log[t0 + 1] !== 1'b1 || addr_log[t0 + 1] !== 8'h10) begin
      n_fail++;
      $display("FAIL basic_busy_addr: busy T=%b T+1=%b addr T+1=%h required 0 1 10",
               busy_log[t0], busy_log[t0 + 1], addr_log[t0 + 1]);
    end
    n_asserts++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_done_pulses: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int t0, td, tt, bad;
    fill_ramp();
    run_cmd(16, 4, 2, 100, t0, td);
    ready_mode = 0;
    repeat (3) @(negedge clock);
    n_asserts++;
    if (rx_data.size() != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words required 4", rx_data.size());
    end
    tt = t0 + 3;
    for (int i = 0; i < rx_data.size() && i < 4; i++) begin
      tt = (tt + 1 > t0 + 4 + i) ? tt + 1 : t0 + 4 + i;
      while (tt >= t0 + 5 && tt <= t0 + 14) tt++;
      n_asserts++;
      if (rx_data[i] !== 16'(16'h110 + i) || rx_last[i] !== (i == 3) || rx_cyc[i] != tt) begin
        n_fail++;
        $display("FAIL bp_word%0d: data=%h last=%b cyc=T+%0d required %h %b T+%0d", i,
                 rx_data[i], rx_last[i], rx_cyc[i] - t0, 16'(16'h110 + i), i == 3, tt - t0);
      end
    end
    n_asserts++;
    if (td != tt + 1) begin
      n_fail++;
      $display("FAIL bp_done_time: got T+%0d required T+%0d", td - t0, tt + 1 - t0);
    end
    bad = 0;
    for (int c = t0 + 5; c <= t0 + 14; c++)
      if (valid_log[c] !== 1'b1 || data_log[c] !== 16'h111 || last_log[c] !== 1'b0) bad++;
    n_asserts++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d stalled cycles lost valid/data/last, required 0", bad);
    end
  endtask

  task automatic test_wrap();
    int t0, td;
    fill_random();
    run_cmd(254, 4, 0, 100, t0, td);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      n_asserts++;
      if (addr_log[t0 + 1 + i] !== AW'((254 + i) % DEPTH)) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: got %0d required %0d", i, addr_log[t0 + 1 + i],
                 (254 + i) % DEPTH);
      end
    end
    n_asserts++;
    if (rx_data.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d words required 4", rx_data.size());
    end
    for (int i = 0; i < rx_data.size() && i < 4; i++) begin
      n_asserts++;
      if (rx_data[i] !== exp_word(254, i) || rx_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL wrap_word%0d: data=%h last=%b required %h %b", i, rx_data[i], rx_last[i],
                 exp_word(254, i), i == 3);
      end
    end
  endtask

  task automatic test_zero();
    int t0, td, nvalid, nmove;
    logic [AW-1:0] addr_before;
    @(negedge clock);
    addr_before = ram_address;
    run_cmd(8'h33, 0, 0, 20, t0, td);
    repeat (4) @(negedge clock);
    n_asserts++;
    if (td != t0 + 1 || busy_log[t0 + 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done at T+%0d busy=%b required T+1 busy=0", td - t0,
               busy_log[t0 + 1]);
    end
    nvalid = 0;
    nmove  = 0;
    for (int c = t0; c <= t0 + 4; c++) begin
      if (valid_log[c] !== 1'b0) nvalid++;
      if (addr_log[c] !== addr_before) nmove++;
    end
    n_asserts++;
    if (nvalid != 0 || rx_data.size() != 0) begin
      n_fail++;
      $display("FAIL zero_stream: %0d valid cycles, %0d words, required 0", nvalid,
               rx_data.size());
    end
    n_asserts++;
    if (nmove != 0) begin
      n_fail++;
      $display("FAIL zero_addr: address moved in %0d cycles, required 0", nmove);
    end
    n_asserts++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_done_pulses: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_full();
    int t0, td, b, bad;
    fill_random();
    b = $urandom_range(0, DEPTH - 1);
    run_cmd(b, 256, 0, 600, t0, td);
    repeat (2) @(negedge clock);
    n_asserts++;
    if (rx_data.size() != 256) begin
      n_fail++;
      $display("FAIL full_count: got %0d words required 256", rx_data.size());
    end
    bad = 0;
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== exp_word(b, i) || rx_last[i] !== (i == 255) || rx_cyc[i] != t0 + 4 + i)
        bad++;
    n_asserts++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_words: %0d words wrong in data/last/timing, required 0", bad);
    end
    if (rx_data.size() == 256) begin
      n_asserts++;
      if (rx_data[255] !== mem[(b + DEPTH - 1) % DEPTH] || rx_cyc[255] != t0 + 259) begin
        n_fail++;
        $display("FAIL full_last: data=%h at T+%0d required %h at T+259", rx_data[255],
                 rx_cyc[255] - t0, mem[(b + DEPTH - 1) % DEPTH]);
      end
    end
    n_asserts++;
    if (td != t0 + 260) begin
      n_fail++;
      $display("FAIL full_done_time: got T+%0d required T+260", td - t0);
    end
  endtask

  task automatic test_restart_busy();
    int t0, td, bad;
    fill_random();
    clear_rx();
    @(posedge clock);
    #1;
    start = 1'b1; base_addr = 8'h40; count = 9'd6; t0 = cyc; ready_mode = 0;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    start = 1'b1; base_addr = 8'h80; count = 9'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    td = -1;
    for (int i = 0; i < 100 && td < 0; i++) begin
      @(negedge clock);
      if (done) td = cyc;
    end
    repeat (10) @(negedge clock);
    n_asserts++;
    if (td != t0 + 10) begin
      n_fail++;
      $display("FAIL restart_done_time: got T+%0d required T+10", td - t0);
    end
    n_asserts++;
    if (rx_data.size() != 6 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL restart_count: %0d words %0d dones, required 6 words 1 done",
               rx_data.size(), done_cnt);
    end
    bad = 0;
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== exp_word(8'h40, i) || rx_last[i] !== (i == 5)) bad++;
    for (int c = td + 1; c <= td + 10 && td >= 0; c++) if (busy_log[c] !== 1'b0) bad++;
    n_asserts++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL restart_stream: %0d wrong words or busy cycles, required 0", bad);
    end
  endtask

  task automatic test_random();
    int t0, td, b, n, bad;
    for (int it = 0; it < 6; it++) begin
      fill_random();
      b = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 40);
      run_cmd(b, n, 1, 2000, t0, td);
      ready_mode = 0;
      repeat (2) @(negedge clock);
      n_asserts++;
      if (rx_data.size() != n) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d words required %0d", it, rx_data.size(), n);
      end
      bad = 0;
      for (int i = 0; i < rx_data.size(); i++)
        if (rx_data[i] !== exp_word(b, i) || rx_last[i] !== (i == n - 1)) bad++;
      n_asserts++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL rand%0d_words: %0d wrong words (base %0d count %0d), required 0", it, bad,
                 b, n);
      end
      if (rx_cyc.size() > 0) begin
        n_asserts++;
        if (td != rx_cyc[rx_cyc.size() - 1] + 1) begin
          n_fail++;
          $display("FAIL rand%0d_done: done at %0d required %0d", it, td,
                   rx_cyc[rx_cyc.size() - 1] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0, td, seen, nvalid;
    fill_random();
    clear_rx();
    @(posedge clock);
    #1;
    start = 1'b1; base_addr = 8'h20; count = 9'd10; ready_mode = 0;
    @(posedge clock);
    #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && seen < 2; i++) begin
      @(negedge clock);
      if (out_valid && out_ready) seen++;
    end
    n_asserts++;
    if (seen != 2) begin
      n_fail++;
      $display("FAIL rstmid_pre: saw %0d transfers before reset, required 2", seen);
    end
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    @(negedge clock);
    n_asserts++;
    if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== '0 || ram_address !== '0)
    begin
      n_fail++;
      $display("FAIL rstmid_values: busy/done/valid/last=%b data=%h addr=%h required all 0",
               {busy, done, out_valid, out_last}, out_data, ram_address);
    end
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    nvalid = 0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) nvalid++;
    end
    n_asserts++;
    if (nvalid != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: %0d cycles with activity after reset, required 0", nvalid);
    end
    run_cmd(8'hc0, 5, 0, 100, t0, td);
    repeat (2) @(negedge clock);
    n_asserts++;
    if (rx_data.size() != 5) begin
      n_fail++;
      $display("FAIL rstmid_new_count: got %0d words required 5", rx_data.size());
    end
    for (int i = 0; i < rx_data.size() && i < 5; i++) begin
      n_asserts++;
      if (rx_data[i] !== exp_word(8'hc0, i) || rx_last[i] !== (i == 4)) begin
        n_fail++;
        $display("FAIL rstmid_new_word%0d: data=%h last=%b required %h %b", i, rx_data[i],
                 rx_last[i], exp_word(8'hc0, i), i == 4);
      end
    end
  endtask

  initial begin
    fill_ramp();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_full();
    test_restart_busy();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
